// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: instruction-memory handshake, decode stall/redirect inputs and the IF/ID outputs.
// The master modport belongs to the fetch stage. The slave modport belongs to its environment.
interface fetch_stage_if #(
    parameter int unsigned N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;
    logic         stall_d;
    logic         br_taken;
    logic [N-1:0] br_target;
    logic         fd_valid;
    logic [N-1:0] fd_inst;
    logic [N-1:0] fd_pc;

    modport master (
        output imem_req, imem_addr, fd_valid, fd_inst, fd_pc,
        input  imem_ack, imem_rdata, stall_d, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, fd_valid, fd_inst, fd_pc,
        output imem_ack, imem_rdata, stall_d, br_taken, br_target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with the IF/ID register and a one-entry stall buffer.
// It keeps at most one memory request outstanding, and a branch redirect drains the wrong-path request.
module fetch_stage #(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] NOP_INST = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam logic [N-1:0] FOUR  = N'(4);
    localparam logic [N-1:0] EIGHT = N'(8);
    localparam logic [N-1:0] ALIGN = ~N'(3);

    typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} state_t;

    state_t       state_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] addr_q;
    logic         req_q;
    logic [N-1:0] buf_inst_q;
    logic [N-1:0] buf_pc_q;
    logic         fd_valid_q;
    logic [N-1:0] fd_inst_q;
    logic [N-1:0] fd_pc_q;

    logic [N-1:0] br_pc_d;
    logic [N-1:0] pc_inc_d;

    assign br_pc_d  = bus.br_target & ALIGN;
    assign pc_inc_d = pc_q + FOUR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
            fd_valid_q <= 1'b0;
            fd_inst_q  <= NOP_INST;
            fd_pc_q    <= RESET_PC + EIGHT;
        end else if (bus.br_taken) begin
            pc_q       <= br_pc_d;
            req_q      <= 1'b1;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
            fd_valid_q <= 1'b0;
            fd_inst_q  <= NOP_INST;
            // A redirect that lands on the ack cycle of a drain ends that drain.
            // Otherwise the old address would be fetched a second time.
            if ((state_q == REQ || state_q == DROP) && !bus.imem_ack) begin
                state_q <= DROP;
            end else begin
                state_q <= REQ;
                addr_q  <= br_pc_d;
            end
        end else begin
            if (!bus.stall_d) begin
                fd_valid_q <= 1'b0;
                fd_inst_q  <= NOP_INST;
            end
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        pc_q <= pc_inc_d;
                        if (bus.stall_d) begin
                            buf_inst_q <= bus.imem_rdata;
                            buf_pc_q   <= pc_q;
                            req_q      <= 1'b0;
                            state_q    <= FULL;
                        end else begin
                            fd_valid_q <= 1'b1;
                            fd_inst_q  <= bus.imem_rdata;
                            fd_pc_q    <= pc_q + EIGHT;
                            addr_q     <= pc_inc_d;
                        end
                    end
                end
                FULL: begin
                    if (!bus.stall_d) begin
                        fd_valid_q <= 1'b1;
                        fd_inst_q  <= buf_inst_q;
                        fd_pc_q    <= buf_pc_q + EIGHT;
                        req_q      <= 1'b1;
                        addr_q     <= pc_q;
                        state_q    <= REQ;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        addr_q  <= pc_q;
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.fd_valid  = fd_valid_q;
    assign bus.fd_inst   = fd_inst_q;
    assign bus.fd_pc     = fd_pc_q;

    ack_only_when_requested: assert property (
        @(posedge clk) disable iff (!rst_n) bus.imem_ack |-> bus.imem_req
    );
endmodule
